// File: rtl/codec_cfg_pkg.sv
// Shared constants for the codec power-up sequencer: register table, FSM states,
// default slave address and the byte-select helper used to load the shift register.
package codec_cfg_pkg;

   localparam logic [6:0] DEF_DEV_ADDR = 7'h1A;

   // {addr7, data9}: reset, power, format, sampling, line/headphone levels, paths, active
   localparam logic [15:0] CFG_TABLE [0:15] = '{
      16'h1E00, 16'h0C10, 16'h0E42, 16'h1000,
      16'h0017, 16'h0217, 16'h0812, 16'h0A00,
      16'h0C00, 16'h1201, 16'h0000, 16'h0000,
      16'h0000, 16'h0000, 16'h0000, 16'h0000
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BYTE,
      ST_STOP,
      ST_GAP
   } cfg_state_t;

   // sel 0: slave write byte, 1: {addr, data[8]}, 2: data[7:0]
   function automatic logic [7:0] cfg_byte(input logic [6:0] dev,
                                           input logic [3:0] idx,
                                           input logic [1:0] sel);
      logic [15:0] word;
      word = CFG_TABLE[idx];
      case (sel)
         2'd0:    return {dev, 1'b0};
         2'd1:    return word[15:8];
         default: return word[7:0];
      endcase
   endfunction

endpackage

// File: rtl/codec_i2c_tick.sv
// Quarter-bit timebase: counts 0..QTR_DIV-1 while enabled, held at 0 otherwise.
module codec_i2c_tick #(
   parameter int QTR_DIV = 208
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic qtick
);

   localparam int CW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(QTR_DIV - 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || !en)       cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + CW'(1);
   end

   assign qtick = en && (cnt == LAST);

endmodule

// File: rtl/codec_i2c_config.sv
// Codec configuration sequencer: one 3-byte I2C write per table entry, open-drain SDA,
// push-pull SCL, all bus changes aligned to the quarter-bit tick.
module codec_i2c_config
   import codec_cfg_pkg::*;
#(
   parameter int         QTR_DIV  = 208,
   parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
   parameter int         NUM_REGS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       scl_out,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [3:0] reg_idx
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

   cfg_state_t state, state_d;
   logic [1:0] q, q_d;
   logic [3:0] bit_cnt, bit_cnt_d;
   logic [1:0] byte_cnt, byte_cnt_d;
   logic [7:0] shreg, shreg_d;
   logic       busy_d, done_d, ack_err_d, scl_d, sda_oe_d;
   logic [3:0] reg_idx_d;
   logic       qtick;

   codec_i2c_tick #(.QTR_DIV(QTR_DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .en    (busy),
      .qtick (qtick)
   );

   // Bus levels {scl, sda_oe} for a given state and quarter; data bits drive only zeros.
   function automatic logic [1:0] bus_level(input cfg_state_t st, input logic [1:0] ph,
                                            input logic [3:0] bc, input logic b7);
      case (st)
         ST_START: return {ph != 2'd3, ph != 2'd0};
         ST_BYTE:  return {(ph == 2'd1) || (ph == 2'd2), (bc != 4'd8) && !b7};
         ST_STOP:  return {ph != 2'd0, ph < 2'd2};
         default:  return 2'b10;
      endcase
   endfunction

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state;
      q_d        = q;
      bit_cnt_d  = bit_cnt;
      byte_cnt_d = byte_cnt;
      shreg_d    = shreg;
      busy_d     = busy;
      done_d     = done;
      ack_err_d  = ack_err;
      reg_idx_d  = reg_idx;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_START;
               q_d       = 2'd0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
               ack_err_d = 1'b0;
               reg_idx_d = 4'd0;
            end
         end
         ST_START: begin
            if (qtick) begin
               q_d = q + 2'd1;
               if (q == 2'd3) begin
                  state_d    = ST_BYTE;
                  bit_cnt_d  = 4'd0;
                  byte_cnt_d = 2'd0;
                  shreg_d    = cfg_byte(DEV_ADDR, reg_idx, 2'd0);
               end
            end
         end
         ST_BYTE: begin
            if (qtick) begin
               q_d = q + 2'd1;
               if (q == 2'd2 && bit_cnt == 4'd8 && sda_in) ack_err_d = 1'b1;
               if (q == 2'd3) begin
                  if (bit_cnt != 4'd8) begin
                     bit_cnt_d = bit_cnt + 4'd1;
                     shreg_d   = {shreg[6:0], 1'b0};
                  end else if (ack_err || byte_cnt == 2'd2) begin
                     state_d = ST_STOP;
                  end else begin
                     byte_cnt_d = byte_cnt + 2'd1;
                     bit_cnt_d  = 4'd0;
                     shreg_d    = cfg_byte(DEV_ADDR, reg_idx, byte_cnt + 2'd1);
                  end
               end
            end
         end
         ST_STOP: begin
            if (qtick) begin
               q_d = q + 2'd1;
               if (q == 2'd3) begin
                  if (ack_err) begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                  end else begin
                     state_d = ST_GAP;
                  end
               end
            end
         end
         ST_GAP: begin
            if (qtick) begin
               q_d = q + 2'd1;
               if (q == 2'd3) begin
                  if (reg_idx == LAST_IDX) begin
                     state_d = ST_IDLE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     state_d   = ST_START;
                     reg_idx_d = reg_idx + 4'd1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Pins are registered from the next-phase decode so they never glitch.
      {scl_d, sda_oe_d} = bus_level(state_d, q_d, bit_cnt_d, shreg_d[7]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         q        <= 2'd0;
         bit_cnt  <= 4'd0;
         byte_cnt <= 2'd0;
         shreg    <= 8'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         ack_err  <= 1'b0;
         reg_idx  <= 4'd0;
         scl_out  <= 1'b1;
         sda_oe   <= 1'b0;
      end else begin
         state    <= state_d;
         q        <= q_d;
         bit_cnt  <= bit_cnt_d;
         byte_cnt <= byte_cnt_d;
         shreg    <= shreg_d;
         busy     <= busy_d;
         done     <= done_d;
         ack_err  <= ack_err_d;
         reg_idx  <= reg_idx_d;
         scl_out  <= scl_d;
         sda_oe   <= sda_oe_d;
      end
   end

endmodule

// File: tb/tb_codec_i2c_config.sv
// Bench for codec_i2c_config: I2C slave BFM with NACK injection, bus protocol monitor,
// and a table-driven model of the expected byte stream and timing.
module tb_codec_i2c_config;
   import codec_cfg_pkg::*;

   localparam int Q = 4;
   localparam int N = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       sda_in;
   logic       sda_oe, scl_out, busy, done, ack_err;
   logic [3:0] reg_idx;
   logic       sda_bus;
   logic       slave_low = 1'b0;

   int checks = 0;
   int errors = 0;

   // Monitor / BFM state (written only by the monitor process)
   logic [7:0] got[$];
   int         frames = 0, stops = 0, proto_err = 0, busy_cycles = 0;
   int         bit_n = 0, byte_in_frame = 0, run = 0;
   logic       in_frame = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;
   logic [7:0] shift = 8'd0;

   // NACK request (written only by the stimulus process)
   int nack_abs = -1;
   int nack_byte = 0;

   assign sda_bus = !(sda_oe || slave_low);
   assign sda_in  = sda_bus;

   always #5 clk = ~clk;

   codec_i2c_config #(.QTR_DIV(Q), .NUM_REGS(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .sda_in  (sda_in),
      .sda_oe  (sda_oe),
      .scl_out (scl_out),
      .busy    (busy),
      .done    (done),
      .ack_err (ack_err),
      .reg_idx (reg_idx)
   );

   always @(negedge clk) begin
      logic c, s;
      c = scl_out;
      s = sda_bus;
      if (busy) busy_cycles++;
      if (rst) begin
         in_frame  = 1'b0;
         bit_n     = 0;
         slave_low = 1'b0;
         prev_scl  = 1'b1;
         prev_sda  = 1'b1;
         run       = 0;
      end else begin
         if (c && prev_scl && s != prev_sda) begin
            if (!s) begin
               if (in_frame && bit_n != 0) proto_err++;
               in_frame = 1'b1; bit_n = 0; byte_in_frame = 0; frames++;
            end else begin
               if (in_frame && bit_n > 1) proto_err++;
               in_frame = 1'b0; stops++;
            end
         end
         if (c && !prev_scl && in_frame) begin
            if (run != 2*Q) proto_err++;
            if (bit_n < 8) shift = {shift[6:0], s};
            bit_n++;
         end
         if (!c && prev_scl && in_frame) begin
            if (bit_n != 0 && run != 2*Q) proto_err++;
            if (bit_n == 8) begin
               got.push_back(shift);
               slave_low = !((frames - 1) == nack_abs && byte_in_frame == nack_byte);
            end else if (bit_n == 9) begin
               slave_low = 1'b0;
               bit_n = 0;
               byte_in_frame++;
            end
         end
         if (c == prev_scl) run++;
         else run = 1;
         prev_scl = c;
         prev_sda = s;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      @(negedge clk);
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'd0);
   endtask

   // nf < 0: every write ACKed; otherwise NACK byte nb of entry nf.
   task automatic run_and_check(input string tag, input int nf, input int nb, input int extra_at);
      logic [7:0] exp_q[$];
      int base, f0, s0, b0, pe0, exp_busy, dlt;
      logic stop_flag = 1'b0;
      base = got.size(); f0 = frames; s0 = stops; b0 = busy_cycles; pe0 = proto_err;
      nack_abs  = (nf < 0) ? -1 : f0 + nf;
      nack_byte = nb;
      for (int f = 0; f < N && !stop_flag; f++) begin
         for (int b = 0; b < 3 && !stop_flag; b++) begin
            logic [15:0] w;
            w = CFG_TABLE[f];
            exp_q.push_back(b == 0 ? {DEF_DEV_ADDR, 1'b0} : (b == 1 ? w[15:8] : w[7:0]));
            if (f == nf && b == nb) stop_flag = 1'b1;
         end
      end
      exp_busy = (nf < 0) ? N * 120 * Q : Q * (120 * nf + 8 + 36 * (nb + 1));

      pulse_start();
      @(negedge clk);
      check({tag, "_accept_busy"}, 32'(busy), 32'd1);
      check({tag, "_accept_done"}, 32'(done), 32'd0);
      check({tag, "_accept_ackerr"}, 32'(ack_err), 32'd0);
      check({tag, "_accept_idx"}, 32'(reg_idx), 32'd0);
      if (extra_at >= 0) begin
         repeat (extra_at) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
      end
      wait_idle(4000);
      repeat (2) @(negedge clk);

      check({tag, "_nbytes"}, 32'(got.size() - base), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++)
         check($sformatf("%s_byte%0d", tag, k),
               32'((base + k < got.size()) ? got[base + k] : 8'hxx), 32'(exp_q[k]));
      check({tag, "_stops"}, 32'(stops - s0), 32'((nf < 0) ? N : nf + 1));
      dlt = busy_cycles - b0;
      check({tag, "_busy_len"}, 32'(dlt >= exp_busy - 1 && dlt <= exp_busy + 1), 32'd1);
      check({tag, "_done"}, 32'(done), 32'(nf < 0));
      check({tag, "_ackerr"}, 32'(ack_err), 32'(nf >= 0));
      check({tag, "_idx"}, 32'(reg_idx), 32'((nf < 0) ? N - 1 : nf));
      check({tag, "_protocol"}, 32'(proto_err - pe0), 32'd0);
      check({tag, "_bus_idle"}, 32'({scl_out, sda_oe}), 32'b10);
   endtask

   initial begin
      int n, base;
      int rf, rb;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_scl", 32'(scl_out), 32'd1);
      check("rst_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ackerr", 32'(ack_err), 32'd0);
      check("rst_idx", 32'(reg_idx), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      run_and_check("full", -1, 0, -1);
      run_and_check("nack_e1b1", 1, 1, -1);
      rf = $urandom_range(0, N - 1);
      rb = $urandom_range(0, 2);
      run_and_check($sformatf("nack_e%0db%0d", rf, rb), rf, rb, -1);
      run_and_check("mid_start", -1, 0, $urandom_range(5, 1000));
      run_and_check("restart", -1, 0, -1);

      // Reset while entry 1 is on the bus
      nack_abs = -1;
      base = got.size();
      pulse_start();
      n = 0;
      while (got.size() < base + 4 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("rst_mid_reach", 32'(got.size() >= base + 4), 32'd1);
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_scl", 32'(scl_out), 32'd1);
      check("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_idx", 32'(reg_idx), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      run_and_check("after_rst", -1, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
